// File: rtl/vote_argmax_reader.sv
// Result-interface reader: snapshots packed vote counters on a finish rise, scans one class
// per clock, and hands back winner, vote count, margin and tie over valid/ready.
module vote_argmax_reader #(
    parameter int unsigned bitlength   = 12,
    parameter int unsigned output_dim  = 10,
    parameter int unsigned index_width = 4
) (
    input  logic                              clock,
    input  logic                              reset,
    input  logic                              finish,
    input  logic [output_dim*bitlength-1:0]   VoteData,
    input  logic                              result_ready,
    output logic                              result_valid,
    output logic [index_width-1:0]            ClassIndex,
    output logic [bitlength-1:0]              MaxVotes,
    output logic [bitlength-1:0]              Margin,
    output logic                              tie,
    output logic                              busy,
    output logic                              overrun
);

    typedef enum logic [1:0] {StIdle, StScan, StOut} state_e;

    state_e                          state_q, state_d;
    logic                            finish_q;
    logic                            trigger;
    logic [output_dim*bitlength-1:0] snap_q, snap_d;
    logic [index_width-1:0]          idx_q, idx_d;
    logic [index_width-1:0]          bidx_q, bidx_d;
    logic [bitlength-1:0]            best_q, best_d;
    logic [bitlength-1:0]            second_q, second_d;
    logic                            stie_q, stie_d;
    logic                            valid_q, valid_d;
    logic [index_width-1:0]          cls_q, cls_d;
    logic [bitlength-1:0]            max_q, max_d;
    logic [bitlength-1:0]            margin_q, margin_d;
    logic                            tie_q, tie_d;
    logic                            overrun_q, overrun_d;
    logic [bitlength-1:0]            v;
    logic                            last_idx;

    assign trigger  = finish & ~finish_q;
    assign last_idx = (idx_q == index_width'(output_dim - 1));

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q   <= StIdle;
            finish_q  <= 1'b0;
            snap_q    <= '0;
            idx_q     <= '0;
            bidx_q    <= '0;
            best_q    <= '0;
            second_q  <= '0;
            stie_q    <= 1'b0;
            valid_q   <= 1'b0;
            cls_q     <= '0;
            max_q     <= '0;
            margin_q  <= '0;
            tie_q     <= 1'b0;
            overrun_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            finish_q  <= finish;
            snap_q    <= snap_d;
            idx_q     <= idx_d;
            bidx_q    <= bidx_d;
            best_q    <= best_d;
            second_q  <= second_d;
            stie_q    <= stie_d;
            valid_q   <= valid_d;
            cls_q     <= cls_d;
            max_q     <= max_d;
            margin_q  <= margin_d;
            tie_q     <= tie_d;
            overrun_q <= overrun_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle:  if (trigger) state_d = StScan;
            StScan:  if (last_idx) state_d = StOut;
            StOut:   if (result_ready) state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    // Class mux for the current scan index.
    always_comb begin
        v = '0;
        for (int unsigned i = 0; i < output_dim; i++) begin
            if (idx_q == index_width'(i)) v = snap_q[i*bitlength +: bitlength];
        end
    end

    always_comb begin
        snap_d    = snap_q;
        idx_d     = idx_q;
        bidx_d    = bidx_q;
        best_d    = best_q;
        second_d  = second_q;
        stie_d    = stie_q;
        valid_d   = valid_q;
        cls_d     = cls_q;
        max_d     = max_q;
        margin_d  = margin_q;
        tie_d     = tie_q;
        // A rise while busy (including the handshake edge) is dropped and remembered.
        overrun_d = overrun_q | (trigger & (state_q != StIdle));
        unique case (state_q)
            StIdle: begin
                if (trigger) begin
                    snap_d = VoteData;
                    idx_d  = '0;
                end
            end
            StScan: begin
                if (idx_q == '0) begin
                    best_d   = v;
                    bidx_d   = '0;
                    second_d = '0;
                    stie_d   = 1'b0;
                end else if (v > best_q) begin
                    second_d = best_q;
                    best_d   = v;
                    bidx_d   = idx_q;
                    stie_d   = 1'b0;
                end else if (v == best_q) begin
                    stie_d   = 1'b1;
                    second_d = v;
                end else if (v > second_q) begin
                    second_d = v;
                end
                idx_d = idx_q + 1'b1;
                if (last_idx) begin
                    cls_d    = bidx_d;
                    max_d    = best_d;
                    margin_d = best_d - second_d;
                    tie_d    = stie_d;
                    valid_d  = 1'b1;
                end
            end
            StOut: begin
                if (result_ready) valid_d = 1'b0;
            end
            default: ;
        endcase
    end

    assign result_valid = valid_q;
    assign ClassIndex   = cls_q;
    assign MaxVotes     = max_q;
    assign Margin       = margin_q;
    assign tie          = tie_q;
    assign busy         = (state_q != StIdle);
    assign overrun      = overrun_q;

endmodule
